stage_stall_buffer: RTL

// - Stage-side end of the central stall protocol: the per-stage elastic buffer that obeys the stall
//   it is given and raises the stall request that is sent back to the central stall unit.
// - The stall unit registers its decision (1-cycle latency), so upstream keeps sending for

---
 rtl/pa_pipe_pkg.sv | 21 ++
 rtl/stall_fifo_mem.sv | 26 ++
 rtl/stage_stall_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/pa_pipe_pkg.sv
// Shared pipeline types and constants for the per-stage stall buffers.
package pa_pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } stall_fsm_t;

  localparam int PIPE_DATA_W = 64;

  // Smallest n with 2**n >= value; sizes pointers and occupancy counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stall_fifo_mem.sv
// Register-array storage for the stall buffer: synchronous write, combinational read.
module stall_fifo_mem import pa_pipe_pkg::*; #(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int DEPTH  = 4,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Head is read straight from the array so a buffered entry costs no extra cycle.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stage_stall_buffer.sv
// Per-stage elastic buffer: obeys the incoming stall, absorbs in-flight pushes and
// raises a hysteretic stall request back to the central stall unit.
module stage_stall_buffer import pa_pipe_pkg::*; #(
  parameter int DATA_W    = PIPE_DATA_W,
  parameter int DEPTH     = 4,
  parameter int STALL_LAT = 1,
  parameter int HI_MARK   = DEPTH - STALL_LAT,
  parameter int LO_MARK   = 1,
  localparam int PTR_W    = clog2(DEPTH),
  localparam int CNT_W    = clog2(DEPTH) + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              stallReq_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, count_next;
  logic             overflow_q, overflow_d;
  stall_fsm_t       state_q, state_d;
  logic             full, pop, push, wr_en;

  assign valid_o    = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign pop        = valid_o & ~stall_i;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign push       = valid_i & (~full | pop);
  assign count_next = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  assign wr_en      = push & ~flush_i;

  stall_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock_i   (clock_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_i),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_o)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_next;
    overflow_d = overflow_q;
    state_d    = state_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = RUN;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Dropped payload must never go unnoticed; the flag is sticky until reset.
      if (valid_i && full && !pop) overflow_d = 1'b1;
      case (state_q)
        RUN:     if (count_next >= CNT_W'(HI_MARK)) state_d = HOLD;
        HOLD:    if (count_next <= CNT_W'(LO_MARK)) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign stallReq_o = (state_q == HOLD);

endmodule
